// File: rtl/mmio_timer_bank.sv
// Bank of NCH memory-mapped timer channels: per-channel prescaler, compare, free-run /
// auto-reload / one-shot modes, sticky match flags and a combined interrupt.
module mmio_timer_bank #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    localparam int CH_W = ADDR_W - 2;
    localparam logic [CH_W-1:0] NCH_IDX = CH_W'(NCH);
    localparam logic [31:0] ID_VAL = {16'h7B01, 8'(CNT_W), 8'(NCH)};

    logic [CH_W-1:0] ch;
    logic [1:0]      off;
    logic            wr_status;

    logic [NCH-1:0][31:0] rd_ctrl;
    logic [NCH-1:0][31:0] rd_presc;
    logic [NCH-1:0][31:0] rd_count;
    logic [NCH-1:0][31:0] rd_cmp;
    logic [NCH-1:0]       status_vec;
    logic [NCH-1:0]       irq_vec;

    // Upper write-data bits beyond the register widths are deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata};

    assign ch        = addr[ADDR_W-1:2];
    assign off       = addr[1:0];
    assign wr_status = sel && we && (ch == NCH_IDX) && (off == 2'd0);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [3:0]       ctrl_q;
        logic [PRE_W-1:0] presc_q;
        logic [PRE_W-1:0] pcnt_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] cmp_q;
        logic             status_q;

        logic wr_hit;
        logic wr_ctrl;
        logic wr_presc;
        logic wr_count;
        logic wr_cmp;
        logic en;
        logic tick;
        logic match;
        logic pcnt_clr;

        assign wr_hit   = sel && we && (ch == CH_W'(g));
        assign wr_ctrl  = wr_hit && (off == 2'd0);
        assign wr_presc = wr_hit && (off == 2'd1);
        assign wr_count = wr_hit && (off == 2'd2);
        assign wr_cmp   = wr_hit && (off == 2'd3);

        assign en    = ctrl_q[0];
        assign tick  = en && (pcnt_q == presc_q);
        // A CPU write to COUNT suppresses the compare for that cycle.
        assign match = tick && !wr_count && (count_q == cmp_q);

        assign pcnt_clr = wr_presc || (wr_ctrl && wdata[0] && !en) || !en || tick;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                ctrl_q   <= '0;
                presc_q  <= '0;
                pcnt_q   <= '0;
                count_q  <= '0;
                cmp_q    <= '1;
                status_q <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    ctrl_q <= wdata[3:0];
                end else if (match && !ctrl_q[1] && ctrl_q[2]) begin
                    ctrl_q[0] <= 1'b0;
                end

                if (wr_presc) begin
                    presc_q <= wdata[PRE_W-1:0];
                end

                if (wr_cmp) begin
                    cmp_q <= wdata[CNT_W-1:0];
                end

                if (pcnt_clr) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_q + PRE_W'(1);
                end

                if (wr_count) begin
                    count_q <= wdata[CNT_W-1:0];
                end else if (tick) begin
                    if (match && ctrl_q[1]) begin
                        count_q <= '0;
                    end else if (!(match && ctrl_q[2])) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end

                // Set beats a simultaneous write-1-to-clear.
                if (match) begin
                    status_q <= 1'b1;
                end else if (wr_status && wdata[g]) begin
                    status_q <= 1'b0;
                end
            end
        end

        assign rd_ctrl[g]    = {28'd0, ctrl_q};
        assign rd_presc[g]   = 32'(presc_q);
        assign rd_count[g]   = 32'(count_q);
        assign rd_cmp[g]     = 32'(cmp_q);
        assign status_vec[g] = status_q;
        assign irq_vec[g]    = status_q && ctrl_q[3];
    end

    assign irq = |irq_vec;

    always_comb begin
        rdata = '0;
        if (sel) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch == CH_W'(i)) begin
                    case (off)
                        2'd0:    rdata = rd_ctrl[i];
                        2'd1:    rdata = rd_presc[i];
                        2'd2:    rdata = rd_count[i];
                        default: rdata = rd_cmp[i];
                    endcase
                end
            end
            if (ch == NCH_IDX) begin
                case (off)
                    2'd0:    rdata = 32'(status_vec);
                    2'd1:    rdata = ID_VAL;
                    default: rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank: default 4-channel/32-bit build plus a
// 2-channel/8-bit build for wrap and truncation behaviour.
module tb_mmio_timer_bank;

    logic        clock;
    logic        reset_n;
    logic        sel, we;
    logic [5:0]  addr;
    logic [31:0] wdata, rdata;
    logic        irq;

    logic        sel8, we8;
    logic [3:0]  addr8;
    logic [31:0] wdata8, rdata8;
    logic        irq8;

    int tests  = 0;
    int failed = 0;
    logic [31:0] v;

    mmio_timer_bank dut (
        .clock(clock), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    mmio_timer_bank #(.NCH(2), .CNT_W(8), .PRE_W(16), .ADDR_W(4)) dut8 (
        .clock(clock), .reset_n(reset_n), .sel(sel8), .we(we8), .addr(addr8),
        .wdata(wdata8), .rdata(rdata8), .irq(irq8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clock);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clock);
        sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic wr8(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        sel8 = 1'b1; we8 = 1'b1; addr8 = a; wdata8 = d;
        @(negedge clock);
        sel8 = 1'b0; we8 = 1'b0; addr8 = '0; wdata8 = '0;
    endtask

    task automatic rd8_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        sel8 = 1'b1; we8 = 1'b0; addr8 = a;
        #1;
        d = rdata8;
        sel8 = 1'b0;
        chk(tag, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        sel = 0; we = 0; addr = '0; wdata = '0;
        sel8 = 0; we8 = 0; addr8 = '0; wdata8 = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Reset mid-count
        wr(6'd3, 32'h0000_1234);
        wr(6'd0, 32'h1);
        repeat (5) @(negedge clock);
        rd_chk("pre_reset_count", 6'd2, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        rd_chk("rst_count", 6'd2, 32'd0);
        rd_chk("rst_cmp", 6'd3, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", 6'd0, 32'd0);
        rd_chk("rst_status", 6'd16, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rd_chk("id", 6'd17, 32'h7B01_2004);
        sel = 1'b0; addr = 6'd17; #1;
        chk("rdata_sel0", rdata, 32'd0);

        // Prescaled free-run on ch0
        wr(6'd1, 32'd3);
        wr(6'd0, 32'd1);
        repeat (3) @(negedge clock);
        rd_chk("presc_before_first", 6'd2, 32'd0);
        @(negedge clock);
        rd_chk("presc_first_inc", 6'd2, 32'd1);
        repeat (36) @(negedge clock);
        rd_chk("presc_40cyc", 6'd2, 32'd10);
        wr(6'd0, 32'd0);
        repeat (8) @(negedge clock);
        rd_chk("presc_disabled_hold", 6'd2, 32'd10);

        // Auto-reload + irq on ch1
        wr(6'd7, 32'd5);
        wr(6'd4, 32'b1011);
        @(negedge clock);
        rd_chk("rl_c1", 6'd6, 32'd1);
        repeat (4) @(negedge clock);
        rd_chk("rl_c5", 6'd6, 32'd5);
        rd_chk("rl_status_pre", 6'd16, 32'd0);
        chk("rl_irq_pre", {31'd0, irq}, 32'd0);
        @(negedge clock);
        rd_chk("rl_wrap0", 6'd6, 32'd0);
        rd_chk("rl_status", 6'd16, 32'b0010);
        chk("rl_irq", {31'd0, irq}, 32'd1);
        @(negedge clock);
        rd_chk("rl_c1_again", 6'd6, 32'd1);
        wr(6'd16, 32'b0010);
        rd_chk("w1c_status", 6'd16, 32'd0);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        rd_chk("w1c_count", 6'd6, 32'd3);
        @(negedge clock);
        wr(6'd16, 32'b0010);
        rd_chk("w1c_collide_count", 6'd6, 32'd0);
        rd_chk("w1c_collide_status", 6'd16, 32'b0010);
        wr(6'd4, 32'd0);
        wr(6'd16, 32'b0010);
        rd_chk("rl_cleared", 6'd16, 32'd0);

        // One-shot on ch2
        wr(6'd11, 32'd3);
        wr(6'd8, 32'b0101);
        repeat (8) @(negedge clock);
        rd_chk("os_count", 6'd10, 32'd3);
        rd_chk("os_ctrl", 6'd8, 32'b0100);
        rd_chk("os_status", 6'd16, 32'b0100);
        chk("os_irq", {31'd0, irq}, 32'd0);
        wr(6'd16, 32'b0100);

        // COUNT write on a tick cycle (PRESC=0 ticks every cycle) on ch3
        wr(6'd12, 32'd1);
        repeat (3) @(negedge clock);
        wr(6'd14, 32'd100);
        rd_chk("coll_written", 6'd14, 32'd100);
        @(negedge clock);
        rd_chk("coll_next", 6'd14, 32'd101);
        wr(6'd12, 32'd0);

        // Decode: unmapped writes ignored, unmapped reads zero
        wr(6'd19, 32'hFFFF_FFFF);
        wr(6'd17, 32'h0);
        rd_chk("unmapped_rd", 6'd19, 32'd0);
        rd_chk("unmapped_hi", 6'd20, 32'd0);
        rd_chk("id_after_wr", 6'd17, 32'h7B01_2004);
        rd_chk("cmp0_intact", 6'd3, 32'hFFFF_FFFF);
        rd_chk("cmp1_intact", 6'd7, 32'd5);
        rd_chk("status_intact", 6'd16, 32'd0);

        // 8-bit build: truncation and silent wrap
        rd8_chk("id8", 4'd9, 32'h7B01_0802);
        wr8(4'd2, 32'h0000_01FE);
        rd8_chk("trunc8", 4'd2, 32'h0000_00FE);
        wr8(4'd3, 32'h10);
        wr8(4'd0, 32'd1);
        @(negedge clock);
        rd8_chk("wrap_ff", 4'd2, 32'h0000_00FF);
        @(negedge clock);
        rd8_chk("wrap_00", 4'd2, 32'h0000_0000);
        rd8_chk("wrap_noflag", 4'd8, 32'd0);
        chk("wrap_irq8", {31'd0, irq8}, 32'd0);
        @(negedge clock);
        rd8_chk("wrap_01", 4'd2, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
